// File: rtl/protocore_pkg.sv
// Shared types and widths for the protocore datapath and its control unit.
// Pure declarations: no logic, no latency, no flow control.
package protocore_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int REG_N  = 2 ** ADDR_W;

  // Encoding is fixed; the control unit drives these values directly.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;
  } alu_out_t;

endpackage

// File: rtl/protocore_alu.sv
// 8-bit combinational ALU: result, zero and carry/borrow/shift-out flag.
// Zero latency, no flow control; outputs follow operands and opcode in-cycle.
module protocore_alu
  import protocore_pkg::*;
(
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  alu_op_e           opcode,
  output alu_out_t          alu_dat
);

  logic [DATA_W:0]   sum9;
  logic [DATA_W:0]   diff9;
  logic [DATA_W-1:0] result;
  logic              carry;

  // Widened by one bit so carry-out and borrow fall out as bit 8.
  assign sum9  = {1'b0, op_a} + {1'b0, op_b};
  assign diff9 = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      ALU_ADD: begin
        result = sum9[DATA_W-1:0];
        carry  = sum9[DATA_W];
      end
      ALU_SUB: begin
        result = diff9[DATA_W-1:0];
        carry  = diff9[DATA_W];
      end
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_XOR: result = op_a ^ op_b;
      ALU_NOT: result = ~op_a;
      ALU_SHL: begin
        result = {op_a[DATA_W-2:0], 1'b0};
        carry  = op_a[DATA_W-1];
      end
      ALU_SHR: begin
        result = {1'b0, op_a[DATA_W-1:1]};
        carry  = op_a[0];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign alu_dat.result = result;
  assign alu_dat.zero   = (result == '0);
  assign alu_dat.carry  = carry;

endmodule

// File: rtl/protocore_datapath.sv
// 16x8 register file (2 async reads, 1 sync write, no bypass) feeding the ALU.
// Reads and ALU are zero latency; writes land on the next edge; no flow control.
module protocore_datapath
  import protocore_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  alu_op_e           alu_opcode,
  output logic [DATA_W-1:0] read_a,
  output logic [DATA_W-1:0] read_b,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_zero,
  output logic              alu_carry
);

  logic [DATA_W-1:0] regs [REG_N];
  alu_out_t          alu_dat;

  // Reset has priority over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[write_addr] <= write_data;
    end
  end

  // Reads see the pre-edge contents; a same-cycle write shows up next cycle.
  assign read_a = regs[ra_addr];
  assign read_b = regs[rb_addr];

  protocore_alu u_alu (
    .op_a    (read_a),
    .op_b    (read_b),
    .opcode  (alu_opcode),
    .alu_dat (alu_dat)
  );

  assign alu_result = alu_dat.result;
  assign alu_zero   = alu_dat.zero;
  assign alu_carry  = alu_dat.carry;

endmodule

// File: tb/tb_protocore_datapath.sv
// Directed bench for protocore_datapath with hand-computed expectations.
module tb_protocore_datapath;
  import protocore_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  alu_op_e           alu_opcode;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  protocore_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .alu_opcode (alu_opcode),
    .read_a     (read_a),
    .read_b     (read_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic sel(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input alu_op_e op);
    ra_addr    = a;
    rb_addr    = b;
    alu_opcode = op;
    #1;
  endtask

  task automatic chk_alu(input string tag, input logic [7:0] r, input logic z, input logic c);
    chk({tag, ".result"}, alu_result, r);
    chk({tag, ".zero"},   alu_zero,   z);
    chk({tag, ".carry"},  alu_carry,  c);
  endtask

  initial begin
    rst        = 1'b1;
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
    ra_addr    = '0;
    rb_addr    = '0;
    alu_opcode = ALU_ADD;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset state on both ports, ADD of zeros
    for (int i = 0; i < REG_N; i++) begin
      sel(4'(i), 4'(REG_N - 1 - i), ALU_ADD);
      chk($sformatf("rst_a[%0d]", i), read_a, 8'h00);
      chk($sformatf("rst_b[%0d]", REG_N - 1 - i), read_b, 8'h00);
    end
    sel(4'd0, 4'd0, ALU_ADD);
    chk_alu("rst_add", 8'h00, 1'b1, 1'b0);

    // 2: ADD with carry out
    wr(4'd3, 8'hF0);
    wr(4'd4, 8'h20);
    sel(4'd3, 4'd4, ALU_ADD);
    chk("r3", read_a, 8'hF0);
    chk("r4", read_b, 8'h20);
    chk_alu("add", 8'h10, 1'b0, 1'b1);

    // 3: SUB both directions, plus logic ops
    sel(4'd4, 4'd3, ALU_SUB);
    chk_alu("sub_borrow", 8'h30, 1'b0, 1'b1);
    sel(4'd3, 4'd4, ALU_SUB);
    chk_alu("sub", 8'hD0, 1'b0, 1'b0);
    sel(4'd3, 4'd4, ALU_AND);
    chk_alu("and", 8'h20, 1'b0, 1'b0);
    sel(4'd3, 4'd4, ALU_OR);
    chk_alu("or", 8'hF0, 1'b0, 1'b0);
    sel(4'd3, 4'd4, ALU_XOR);
    chk_alu("xor", 8'hD0, 1'b0, 1'b0);
    sel(4'd3, 4'd3, ALU_SUB);
    chk_alu("sub_self", 8'h00, 1'b1, 1'b0);

    // 4: read-during-write shows old value, write_en=0 holds
    sel(4'd5, 4'd5, ALU_ADD);
    write_en   = 1'b1;
    write_addr = 4'd5;
    write_data = 8'hAA;
    #1;
    chk("rdw_old", read_a, 8'h00);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    chk("rdw_new_a", read_a, 8'hAA);
    chk("rdw_new_b", read_b, 8'hAA);
    write_data = 8'h3C;
    @(posedge clk);
    #1;
    chk("we0_hold", read_a, 8'hAA);

    // 5: shifts, NOT, XOR self
    wr(4'd1, 8'h81);
    sel(4'd1, 4'd0, ALU_SHL);
    chk_alu("shl", 8'h02, 1'b0, 1'b1);
    sel(4'd1, 4'd0, ALU_SHR);
    chk_alu("shr", 8'h40, 1'b0, 1'b1);
    sel(4'd1, 4'd0, ALU_NOT);
    chk_alu("not", 8'h7E, 1'b0, 1'b0);
    sel(4'd1, 4'd1, ALU_XOR);
    chk_alu("xor_self", 8'h00, 1'b1, 1'b0);

    // top and bottom register addresses
    wr(4'd15, 8'hFF);
    wr(4'd0, 8'h01);
    sel(4'd15, 4'd0, ALU_ADD);
    chk_alu("add_wrap", 8'h00, 1'b1, 1'b1);

    // 6: reset beats a concurrent write
    wr(4'd7, 8'h11);
    sel(4'd7, 4'd3, ALU_ADD);
    chk("r7_pre", read_a, 8'h11);
    rst        = 1'b1;
    write_en   = 1'b1;
    write_addr = 4'd7;
    write_data = 8'h55;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    write_en = 1'b0;
    #1;
    chk("rst_vs_we_r7", read_a, 8'h00);
    chk("rst_vs_we_r3", read_b, 8'h00);
    chk_alu("rst2_add", 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
